// File: rtl/elau_sqr_pkg.sv
// Shared types and sizing helpers for the iterative squarer.
package elau_sqr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of folded partial-product rows for a width-bit squarer.
  function automatic int sqrRows(input int width);
    return width / 2 + 1;
  endfunction

  // COMP cycles needed to add all rows, rowsPerCycle at a time.
  function automatic int sqrIters(input int width, input int rowsPerCycle);
    return (sqrRows(width) + rowsPerCycle - 1) / rowsPerCycle;
  endfunction

  // Width of a register that holds a row index 0..NR.
  function automatic int sqrIdxW(input int width);
    return $clog2(sqrRows(width) + 1);
  endfunction

endpackage

// File: rtl/sqr_pp_row_gen.sv
// One row of the folded squarer partial-product matrix, signed or unsigned.
// Terms are packed column by column: the n-th term landing in a column goes
// to row n. Every column holds at most NR terms, so NR rows cover the matrix.
// Column term order: diagonal, off-diagonal pairs (ascending i), corrections.
module sqr_pp_row_gen
  import elau_sqr_pkg::*;
#(
  parameter int width = 8,
  parameter int riw   = 4
) (
  input  logic [width-1:0]   x,
  input  logic               sgn,
  input  logic [riw-1:0]     row,
  output logic [2*width-1:0] pp
);

  // Signed mode rewrites -x(i)x(W-1)2^(i+W) as x(W-1)~x(i)2^(i+W) and folds
  // the resulting constants into ~x(W-1) + 1 at bit 2W-1 and x(W-1)*2^W.
  // x(W-1)*2^W goes in as two terms at bit W-1 for even W, one at bit W for
  // odd W, which keeps every column within NR terms.
  function automatic logic [2*width-1:0] build_row(input logic [width-1:0] xv,
                                                   input logic s, input int r);
    logic [2*width-1:0] row_v;
    logic sb;
    logic t;
    int   cnt;
    int   k;
    row_v = '0;
    sb    = xv[width-1];
    for (int c = 0; c < 2 * width; c++) begin
      cnt = 0;
      if ((c % 2) == 0 && (c / 2) < width) begin
        if (cnt == r) row_v[c] = xv[c/2];
        cnt++;
      end
      for (int i = 0; i < width; i++) begin
        k = c - 1 - i;
        if (k > i && k < width) begin
          if (k == width - 1) t = s ? (sb & ~xv[i]) : (xv[i] & sb);
          else                t = xv[i] & xv[k];
          if (cnt == r) row_v[c] = t;
          cnt++;
        end
      end
      if (c == 2 * width - 1) begin
        if (cnt == r) row_v[c] = s & ~sb;
        cnt++;
        if (cnt == r) row_v[c] = s;
        cnt++;
      end
      if ((width % 2) == 0 && c == width - 1) begin
        if (cnt == r) row_v[c] = s & sb;
        cnt++;
        if (cnt == r) row_v[c] = s & sb;
        cnt++;
      end
      if ((width % 2) == 1 && c == width) begin
        if (cnt == r) row_v[c] = s & sb;
        cnt++;
      end
    end
    return row_v;
  endfunction

  // Select the requested row; indices at or beyond NR yield zero.
  always_comb begin
    pp = '0;
    if (int'(row) < sqrRows(width)) pp = build_row(x, sgn, int'(row));
  end

endmodule

// File: rtl/sqr_iter.sv
// Iterative handshaked squarer: adds rowsPerCycle matrix rows per cycle.
//
// state | meaning
// IDLE  | waiting for an operand, InReady=1
// COMP  | accumulating rows idx..idx+R-1 each cycle
// DONE  | result presented on P with OutValid=1 until taken
module sqr_iter
  import elau_sqr_pkg::*;
#(
  parameter int width        = 8,
  parameter int rowsPerCycle = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               InValid,
  output logic               InReady,
  input  logic [width-1:0]   X,
  input  logic               Sgn,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [2*width-1:0] P,
  output logic               Busy
);

  localparam int NR       = sqrRows(width);
  localparam int NI       = sqrIters(width, rowsPerCycle);
  localparam int IDXW     = sqrIdxW(width);
  localparam int RIW      = IDXW + 1;
  localparam int LAST_IDX = (NI - 1) * rowsPerCycle;

  state_t               state, state_nxt;
  logic [width-1:0]     x_q;
  logic                 sgn_q;
  logic [IDXW-1:0]      idx_q;
  logic [2*width-1:0]   acc_q;
  logic [2*width-1:0]   p_q;
  logic [2*width-1:0]   acc_sum;
  logic [2*width-1:0]   rows [rowsPerCycle];
  logic                 accept;
  logic                 xfer;
  logic                 last_iter;

  assign accept    = InValid & InReady;
  assign xfer      = OutValid & OutReady;
  assign last_iter = (idx_q == IDXW'(LAST_IDX));

  for (genvar g = 0; g < rowsPerCycle; g++) begin : g_row
    localparam logic [RIW-1:0] OFS = RIW'(g);
    sqr_pp_row_gen #(.width(width), .riw(RIW)) u_row (
      .x   (x_q),
      .sgn (sgn_q),
      .row (RIW'(idx_q) + OFS),
      .pp  (rows[g])
    );
  end

  // Accumulator plus this cycle's rows, wrapping modulo 2^(2W).
  always_comb begin
    acc_sum = acc_q;
    for (int j = 0; j < rowsPerCycle; j++) acc_sum = acc_sum + rows[j];
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a transfer with a simultaneous accept restarts COMP.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = COMP;
      COMP:    if (last_iter) state_nxt = DONE;
      DONE: begin
        if (accept)    state_nxt = COMP;
        else if (xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; InReady is held low while reset is asserted.
  always_comb begin
    InReady  = 1'b0;
    OutValid = 1'b0;
    Busy     = 1'b0;
    unique case (state)
      IDLE: InReady = 1'b1;
      COMP: Busy = 1'b1;
      DONE: begin
        InReady  = OutReady;
        OutValid = 1'b1;
        Busy     = 1'b1;
      end
      default: ;
    endcase
    if (RST) InReady = 1'b0;
  end

  // Operand capture, accumulation and result register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_q   <= '0;
      sgn_q <= 1'b0;
      idx_q <= '0;
      acc_q <= '0;
      p_q   <= '0;
    end else if (accept) begin
      x_q   <= X;
      sgn_q <= Sgn;
      idx_q <= '0;
      acc_q <= '0;
    end else if (state == COMP) begin
      acc_q <= acc_sum;
      if (last_iter) p_q <= acc_sum;
      else           idx_q <= idx_q + IDXW'(rowsPerCycle);
    end
  end

  assign P = p_q;

endmodule

// File: tb/tb_sqr_iter.sv
// Directed and exhaustive checks of sqr_iter at W=8 (R=1,3,5) and W=5 (R=2).
module tb_sqr_iter;

  logic CLK;
  logic RST;

  logic [2:0]       inv8, ordy8, iny8, ov8, busy8;
  logic [2:0][15:0] p8;
  logic [7:0]       x8;
  logic             s8;

  logic       inv5, ordy5, iny5, ov5, busy5;
  logic [4:0] x5;
  logic       s5;
  logic [9:0] p5;

  int total;
  int bad;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : g8
    sqr_iter #(.width(8), .rowsPerCycle(g == 0 ? 1 : (g == 1 ? 3 : 5))) u_dut (
      .CLK      (CLK),
      .RST      (RST),
      .InValid  (inv8[g]),
      .InReady  (iny8[g]),
      .X        (x8),
      .Sgn      (s8),
      .OutValid (ov8[g]),
      .OutReady (ordy8[g]),
      .P        (p8[g]),
      .Busy     (busy8[g])
    );
  end

  sqr_iter #(.width(5), .rowsPerCycle(2)) u_dut5 (
    .CLK      (CLK),
    .RST      (RST),
    .InValid  (inv5),
    .InReady  (iny5),
    .X        (x5),
    .Sgn      (s5),
    .OutValid (ov5),
    .OutReady (ordy5),
    .P        (p5),
    .Busy     (busy5)
  );

  // Drive one operand into 8-bit instance k with OutReady high; returns P and
  // the number of cycles from accept to OutValid.
  task automatic run_op8(input int k, input logic [7:0] xv, input logic sv,
                         output logic [15:0] pres, output int lat);
    @(negedge CLK);
    x8 = xv; s8 = sv; inv8[k] = 1'b1; ordy8[k] = 1'b1;
    @(negedge CLK);
    inv8[k] = 1'b0; x8 = ~xv;
    lat = 1;
    while (!ov8[k] && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    pres = p8[k];
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    total++; if (iny8[0] !== 1'b0) begin bad++; $display("FAIL reset_inready: got %b want 0", iny8[0]); end
    total++; if (ov8[0] !== 1'b0) begin bad++; $display("FAIL reset_outvalid: got %b want 0", ov8[0]); end
    total++; if (p8[0] !== 16'h0000) begin bad++; $display("FAIL reset_p: got %h want 0000", p8[0]); end
    total++; if (busy8[0] !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy8[0]); end
    total++; if (p5 !== 10'h000 || ov5 !== 1'b0) begin bad++; $display("FAIL reset_w5: got p=%h ov=%b want 000/0", p5, ov5); end
    RST = 1'b0;
    #1;
    total++; if (iny8[0] !== 1'b1) begin bad++; $display("FAIL idle_inready: got %b want 1", iny8[0]); end
  endtask

  task automatic test_unsigned_latency;
    int lat;
    int ready_in_comp;
    ready_in_comp = 0;
    @(negedge CLK);
    x8 = 8'hFF; s8 = 1'b0; ordy8[0] = 1'b1; inv8[0] = 1'b1;
    @(negedge CLK);
    inv8[0] = 1'b0; x8 = 8'h00;
    lat = 1;
    while (!ov8[0] && lat < 40) begin
      if (iny8[0] || !busy8[0]) ready_in_comp++;
      @(negedge CLK);
      lat++;
    end
    total++; if (lat !== 6) begin bad++; $display("FAIL lat_w8r1: got %0d want 6", lat); end
    total++; if (p8[0] !== 16'hFE01) begin bad++; $display("FAIL sq_u_ff: got %h want fe01", p8[0]); end
    total++; if (ready_in_comp !== 0) begin bad++; $display("FAIL inready_comp: got %0d cycles high want 0", ready_in_comp); end
    @(negedge CLK);
    total++; if (ov8[0] !== 1'b0 || iny8[0] !== 1'b1) begin bad++; $display("FAIL after_xfer: got ov=%b iny=%b want 0/1", ov8[0], iny8[0]); end
  endtask

  task automatic test_signed;
    logic [7:0]  xv [6];
    logic        sv [6];
    logic [15:0] ev [6];
    logic [15:0] pr;
    int lat;
    xv = '{8'h80, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'hFE};
    sv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ev = '{16'h4000, 16'h0001, 16'h3F01, 16'h4000, 16'h0000, 16'h0004};
    for (int i = 0; i < 6; i++) begin
      run_op8(0, xv[i], sv[i], pr, lat);
      total++; if (pr !== ev[i]) begin bad++; $display("FAIL sq8_vec%0d: x=%h s=%b got %h want %h", i, xv[i], sv[i], pr, ev[i]); end
      total++; if (lat !== 6) begin bad++; $display("FAIL lat8_vec%0d: got %0d want 6", i, lat); end
    end
  endtask

  task automatic test_w5;
    logic [4:0] xv [4];
    logic       sv [4];
    logic [9:0] ev [4];
    int lat;
    xv = '{5'h10, 5'h1F, 5'h1F, 5'h0F};
    sv = '{1'b1, 1'b0, 1'b1, 1'b1};
    ev = '{10'h100, 10'h3C1, 10'h001, 10'h0E1};
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      x5 = xv[i]; s5 = sv[i]; ordy5 = 1'b1; inv5 = 1'b1;
      @(negedge CLK);
      inv5 = 1'b0; x5 = ~xv[i];
      lat = 1;
      while (!ov5 && lat < 40) begin
        @(negedge CLK);
        lat++;
      end
      total++; if (p5 !== ev[i]) begin bad++; $display("FAIL sq5_vec%0d: x=%h s=%b got %h want %h", i, xv[i], sv[i], p5, ev[i]); end
      total++; if (lat !== 3) begin bad++; $display("FAIL lat5_vec%0d: got %0d want 3", i, lat); end
      @(negedge CLK);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    @(negedge CLK);
    ordy8[0] = 1'b0; x8 = 8'h05; s8 = 1'b0; inv8[0] = 1'b1;
    @(negedge CLK);
    inv8[0] = 1'b0;
    lat = 1;
    while (!ov8[0] && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    total++; if (p8[0] !== 16'h0019) begin bad++; $display("FAIL bp_result: got %h want 0019", p8[0]); end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      total++;
      if (ov8[0] !== 1'b1 || p8[0] !== 16'h0019 || iny8[0] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got ov=%b p=%h iny=%b want 1/0019/0", i, ov8[0], p8[0], iny8[0]);
      end
    end
    ordy8[0] = 1'b1; inv8[0] = 1'b1; x8 = 8'h03;
    #1;
    total++; if (iny8[0] !== 1'b1) begin bad++; $display("FAIL b2b_inready: got %b want 1", iny8[0]); end
    @(negedge CLK);
    inv8[0] = 1'b0; x8 = 8'hAA;
    total++;
    if (ov8[0] !== 1'b0 || busy8[0] !== 1'b1 || iny8[0] !== 1'b0 || p8[0] !== 16'h0019) begin
      bad++;
      $display("FAIL b2b_comp: got ov=%b busy=%b iny=%b p=%h want 0/1/0/0019", ov8[0], busy8[0], iny8[0], p8[0]);
    end
    lat = 1;
    while (!ov8[0] && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    total++; if (lat !== 6) begin bad++; $display("FAIL b2b_lat: got %0d want 6", lat); end
    total++; if (p8[0] !== 16'h0009) begin bad++; $display("FAIL b2b_result: got %h want 0009", p8[0]); end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    @(negedge CLK);
    x8 = 8'hFF; s8 = 1'b0; ordy8[0] = 1'b1; inv8[0] = 1'b1;
    @(negedge CLK);
    inv8[0] = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    total++;
    if (ov8[0] !== 1'b0 || p8[0] !== 16'h0000 || iny8[0] !== 1'b1 || busy8[0] !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: got ov=%b p=%h iny=%b busy=%b want 0/0000/1/0", ov8[0], p8[0], iny8[0], busy8[0]);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (ov8[0] !== 1'b0 || p8[0] !== 16'h0000) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_discard: got %0d cycles with result want 0", seen); end
  endtask

  task automatic test_exhaustive;
    logic [15:0] expv;
    int xs;
    int n;
    bit done;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < 2; s++) begin
        for (int x = 0; x < 256; x++) begin
          xs   = (s == 1 && x >= 128) ? x - 256 : x;
          expv = 16'(xs * xs);
          @(negedge CLK);
          x8 = 8'(x); s8 = 1'(s); inv8[k] = 1'b1;
          n = 0;
          while (!iny8[k] && n < 50) begin
            @(negedge CLK);
            n++;
          end
          if (!iny8[k]) begin
            total++; bad++;
            $display("FAIL ex_accept_timeout: inst=%0d x=%h got iny=0 want 1", k, x);
          end
          @(negedge CLK);
          inv8[k] = 1'b0; x8 = ~8'(x); s8 = ~1'(s);
          n = 0;
          while (!ov8[k] && n < 50) begin
            @(negedge CLK);
            n++;
          end
          done = 1'b0;
          for (int c = 0; c < 50 && !done; c++) begin
            total++;
            if (ov8[k] !== 1'b1 || p8[k] !== expv) begin
              bad++;
              $display("FAIL ex_result: inst=%0d x=%h s=%0d got ov=%b p=%h want 1/%h", k, x, s, ov8[k], p8[k], expv);
              done = 1'b1;
            end
            ordy8[k] = ($urandom_range(0, 3) != 0);
            if (ordy8[k]) done = 1'b1;
            @(negedge CLK);
          end
          total++;
          if (ov8[k] !== 1'b0) begin
            bad++;
            $display("FAIL ex_xfer: inst=%0d x=%h got ov=%b want 0", k, x, ov8[k]);
          end
          ordy8[k] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    RST = 1'b1;
    inv8 = '0; ordy8 = '1; x8 = '0; s8 = 1'b0;
    inv5 = 1'b0; ordy5 = 1'b1; x5 = '0; s5 = 1'b0;
    test_reset;
    test_unsigned_latency;
    test_signed;
    test_w5;
    test_back_to_back;
    test_reset_mid;
    test_exhaustive;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqr_iter.md
Name: sqr_iter

Overview:
- Iterative, handshaked squarer. Computes X*X for a W-bit operand in either signed or unsigned mode, selected per operation.
- Each cycle it accumulates R partial-product rows of the carry-save squarer matrix, trading latency for area.
- It sits beside the combinational squarer partial-product generators in the arithmetic library. It is used where a full array squarer is too large and a multi-cycle result is acceptable.

Parameters:
- width, 8, operand width W; legal range 2..64, odd and even both legal.
- rowsPerCycle, 1, R = partial-product rows added per cycle; legal range 1..NR, where NR = width/2+1 (integer division).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- InValid  in  1  operand valid.
- InReady  out  1  block can accept an operand.
- X  in  width  operand.
- Sgn  in  1  1 = two's-complement operand, 0 = unsigned; sampled with X.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts result.
- P  out  2*width  square of the captured operand.
- Busy  out  1  high in COMP or DONE.

Behaviour:
- Reset: state IDLE. Outputs reset to OutValid=0, P=0, Busy=0, InReady=0. Operand, mode and row-counter registers are cleared.
- Handshakes:
  - Input accept occurs when InValid & InReady.
  - Output transfer occurs when OutValid & OutReady.
  - X and Sgn are sampled only on accept and are ignored otherwise.
- Iteration count: N = ceil(NR/R). Examples: W=8, R=1 gives N=5; R=2 gives N=3; R=5 gives N=1.
- States:
  - IDLE: InReady=1. On accept: capture X and Sgn, clear accumulator, set row index to 0, go to COMP.
  - COMP: InReady=0. Each cycle, add rows [idx, idx+R-1] (rows >= NR contribute 0) to the 2W-bit accumulator, then idx += R. After the N-th COMP cycle, go to DONE.
  - DONE: OutValid=1 and P = accumulator, both held stable until transfer. On transfer with no simultaneous accept, go to IDLE.
- Back-to-back operation: in DONE, InReady = OutReady. A transfer and an accept in the same cycle go directly to COMP with the new operand. The output register keeps the old P until the next DONE, with OutValid=0 in between.
- Latency: accept in cycle t gives OutValid=1 from cycle t+N+1. Throughput is one result per N+1 cycles with OutReady held high.
- P is registered. Outside DONE, P holds its last value, or 0 after reset.
- Arithmetic:
  - The accumulator is modulo 2^(2W).
  - The result is exact for every operand: the maximum unsigned result (2^W-1)^2 and the maximum signed result 2^(2W-2) both fit in 2W bits.
- Row matrix, signed mode: identical to the library's signed squarer matrix. This includes complemented x(k)·x(W-1) terms, the ~x(W-1) correction at bit 2W-1, the constant 1 at row 1, bit 2W-1, and the x(W-1) correction terms (two for even W, one for odd W).
- Row matrix, unsigned mode:
  - Off-diagonal x(i)x(k) (i<k) at bit i+k+1, folded into the same NR rows.
  - Diagonal x(i) at bit 2i.
  - No correction or constant terms.
  - Unused positions are 0.
- Backpressure: OutReady low in DONE holds the state indefinitely, with P stable and InReady=0.
- RST in any state: next cycle is IDLE with reset outputs. An in-flight result is discarded and never presented.
- InValid high while not ready: no effect, and X is not sampled.

Decomposition:
- Shared package elau_sqr_pkg:
  - State enum {IDLE, COMP, DONE}.
  - Function sqrRows(width) = width/2+1.
  - Function sqrIters(width, rowsPerCycle) = ceil.
  - Row-index width constant $clog2(NR+1).
- One sub-module, sqr_pp_row_gen: combinational. Inputs are X, Sgn and a row index. Output is one 2W-bit row of the signed or unsigned matrix.
- The top instantiates R copies of sqr_pp_row_gen (indices idx..idx+R-1) and an R+1-input adder.

Test Plan:
- W=8, R=1, Sgn=0, X=0xFF, OutReady=1 → OutValid exactly 6 cycles after accept; P=0xFE01; InReady low during COMP.
- W=8, R=1, Sgn=1: X=0x80 → P=0x4000; X=0xFF → P=0x0001; X=0x7F → P=0x3F01. Sgn=0, X=0x80 → P=0x4000.
- W=5, R=2 (N=2), Sgn=1, X=5'b10000 → P=0x100; Sgn=0, X=5'b11111 → P=0x3C1. OutValid 3 cycles after accept.
- Backpressure: OutReady=0 for 10 cycles in DONE → P and OutValid stable, InReady=0. Then OutReady=1 together with InValid=1 and X=0x03 → same-cycle transfer and accept; next result P=0x0009.
- Reset mid-COMP (cycle t+2, W=8, R=1) → next cycle IDLE, OutValid=0, P=0, InReady=1; the aborted result never appears.
- Exhaustive random: all X for W=8 in both modes with R∈{1,3,5} and random OutReady stalls → P equals the reference model X*X (signed or unsigned). No handshake protocol violations.
